// File: rtl/hdmi_tmds_encoder.sv
// TMDS character encoder for one HDMI/DVI channel: video 8b/10b, control, guard band and
// (with TMDS_TERC4_EN defined) TERC4 data-island characters. Two-stage registered pipeline.
module hdmi_tmds_encoder #(
  parameter logic [1:0] CHANNEL = 2'd0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_mode,
  input  logic [7:0] i_pix,
  input  logic [1:0] i_ctl,
  input  logic [3:0] i_aux,
  output logic [9:0] o_word
);

  typedef enum logic [1:0] {
    ModeCtl   = 2'b00,
    ModeVid   = 2'b01,
    ModeIsl   = 2'b10,
    ModeGuard = 2'b11
  } mode_e;

  localparam logic [9:0] Ctl0Token = 10'h354;

  function automatic logic [9:0] ctl_token(input logic [1:0] c);
    logic [9:0] tok;
    unique case (c)
      2'd0:    tok = 10'h354;
      2'd1:    tok = 10'h0AB;
      2'd2:    tok = 10'h154;
      default: tok = 10'h2AB;
    endcase
    return tok;
  endfunction

`ifdef TMDS_TERC4_EN
  function automatic logic [9:0] terc4_token(input logic [3:0] a);
    logic [9:0] tok;
    unique case (a)
      4'h0:    tok = 10'h29C;
      4'h1:    tok = 10'h263;
      4'h2:    tok = 10'h2E4;
      4'h3:    tok = 10'h2E2;
      4'h4:    tok = 10'h171;
      4'h5:    tok = 10'h11E;
      4'h6:    tok = 10'h18E;
      4'h7:    tok = 10'h13C;
      4'h8:    tok = 10'h2CC;
      4'h9:    tok = 10'h139;
      4'hA:    tok = 10'h19C;
      4'hB:    tok = 10'h2C6;
      4'hC:    tok = 10'h28E;
      4'hD:    tok = 10'h271;
      4'hE:    tok = 10'h163;
      default: tok = 10'h2C3;
    endcase
    return tok;
  endfunction
`else
  logic unused_aux;
  assign unused_aux = ^i_aux;
`endif

  // Stage 1: transition-minimised q_m and its ones/zeros counts
  logic [3:0] pix_ones;
  logic       use_xnor;
  logic [8:0] qm_d;
  logic [3:0] qm_ones_d;

  always_comb begin
    pix_ones = '0;
    for (int i = 0; i < 8; i++) pix_ones = pix_ones + {3'b000, i_pix[i]};
    use_xnor = (pix_ones > 4'd4) || ((pix_ones == 4'd4) && !i_pix[0]);
    qm_d = '0;
    qm_d[0] = i_pix[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ i_pix[i]) : (qm_d[i-1] ^ i_pix[i]);
    end
    qm_d[8] = ~use_xnor;
    qm_ones_d = '0;
    for (int i = 0; i < 8; i++) qm_ones_d = qm_ones_d + {3'b000, qm_d[i]};
  end

  mode_e      mode_q;
  logic [1:0] ctl_q;
  logic [8:0] qm_q;
  logic [3:0] n1_q;
  logic [3:0] n0_q;
`ifdef TMDS_TERC4_EN
  logic [3:0] aux_q;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mode_q <= ModeCtl;
      ctl_q  <= 2'b00;
      qm_q   <= '0;
      n1_q   <= '0;
      n0_q   <= '0;
`ifdef TMDS_TERC4_EN
      aux_q  <= '0;
`endif
    end else begin
      mode_q <= mode_e'(i_mode);
      ctl_q  <= i_ctl;
      qm_q   <= qm_d;
      n1_q   <= qm_ones_d;
      n0_q   <= 4'd8 - qm_ones_d;
`ifdef TMDS_TERC4_EN
      aux_q  <= i_aux;
`endif
    end
  end

  // Stage 2: DC balancing against the running disparity, plus fixed-token classes
  logic signed [4:0] cnt_q;
  logic signed [4:0] cnt_d;
  logic signed [4:0] diff;
  logic signed [4:0] two_qm8;
  logic signed [4:0] two_nqm8;
  logic        [9:0] word_q;
  logic        [9:0] word_d;

  always_comb begin
    word_d   = Ctl0Token;
    cnt_d    = 5'sd0;
    diff     = $signed({1'b0, n1_q}) - $signed({1'b0, n0_q});
    two_qm8  = qm_q[8] ? 5'sd2 : 5'sd0;
    two_nqm8 = qm_q[8] ? 5'sd0 : 5'sd2;
    unique case (mode_q)
      ModeVid: begin
        if ((cnt_q == 5'sd0) || (n1_q == n0_q)) begin
          word_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
          cnt_d  = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
        end else if (((cnt_q > 5'sd0) && (n1_q > n0_q)) ||
                     ((cnt_q < 5'sd0) && (n0_q > n1_q))) begin
          word_d = {1'b1, qm_q[8], ~qm_q[7:0]};
          cnt_d  = cnt_q + two_qm8 - diff;
        end else begin
          word_d = {1'b0, qm_q[8], qm_q[7:0]};
          cnt_d  = cnt_q + diff - two_nqm8;
        end
      end
      ModeCtl: word_d = ctl_token(ctl_q);
`ifdef TMDS_TERC4_EN
      ModeIsl: word_d = terc4_token(aux_q);
`else
      ModeIsl: word_d = ctl_token(ctl_q);
`endif
      ModeGuard: word_d = (CHANNEL == 2'd1) ? 10'h133 : 10'h2CC;
      default: word_d = Ctl0Token;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      word_q <= Ctl0Token;
      cnt_q  <= 5'sd0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_word = word_q;

endmodule

// File: tb/tb_hdmi_tmds_encoder.sv
// Scoreboard bench for hdmi_tmds_encoder: two instances (CHANNEL 0 and 1) share stimulus and
// are compared against a character-stream reference model with a 2-cycle delay.
module tb_hdmi_tmds_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic [7:0] pix;
  logic [1:0] ctl;
  logic [3:0] aux;
  logic [9:0] word0;
  logic [9:0] word1;

  always #5 clk = ~clk;

  hdmi_tmds_encoder #(.CHANNEL(2'd0)) dut0 (
    .i_clk(clk), .i_reset(reset), .i_mode(mode), .i_pix(pix), .i_ctl(ctl), .i_aux(aux),
    .o_word(word0)
  );

  hdmi_tmds_encoder #(.CHANNEL(2'd1)) dut1 (
    .i_clk(clk), .i_reset(reset), .i_mode(mode), .i_pix(pix), .i_ctl(ctl), .i_aux(aux),
    .o_word(word1)
  );

  logic [9:0] exp0_q[$];
  logic [9:0] exp1_q[$];
  int         due_q[$];
  int         edge_cnt = 0;
  int         errors = 0;
  int         checks = 0;
  int         model_cnt = 0;

  function automatic logic [9:0] ctl_tok(input logic [1:0] c);
    logic [9:0] t[4];
    t = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    return t[c];
  endfunction

  function automatic logic [9:0] terc4_tok(input logic [3:0] a);
    logic [9:0] t[16];
    t = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
          10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3};
    return t[a];
  endfunction

  // Reference character for one request; updates the model's running disparity.
  task automatic encode(input logic [1:0] m, input logic [7:0] p, input logic [1:0] c,
                        input logic [3:0] a, output logic [9:0] w0, output logic [9:0] w1);
    logic [7:0] qm;
    logic       qm8;
    bit         xn;
    int         ones;
    int         zeros;
    w0 = 10'h354;
    if (m == 2'b01) begin
      ones = $countones(p);
      xn = (ones > 4) || (ones == 4 && p[0] == 1'b0);
      qm[0] = p[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? !(qm[i-1] ^ p[i]) : (qm[i-1] ^ p[i]);
      qm8 = !xn;
      ones = $countones(qm);
      zeros = 8 - ones;
      if (model_cnt == 0 || ones == zeros) begin
        w0 = {!qm8, qm8, qm8 ? qm : ~qm};
        model_cnt += qm8 ? (ones - zeros) : (zeros - ones);
      end else if ((model_cnt > 0 && ones > zeros) || (model_cnt < 0 && zeros > ones)) begin
        w0 = {1'b1, qm8, ~qm};
        model_cnt += 2 * int'(qm8) + zeros - ones;
      end else begin
        w0 = {1'b0, qm8, qm};
        model_cnt += ones - zeros - 2 * int'(!qm8);
      end
      if (model_cnt > 10 || model_cnt < -10) $display("model disparity out of range %0d", model_cnt);
      w1 = w0;
    end else begin
      model_cnt = 0;
      if (m == 2'b00) w0 = ctl_tok(c);
`ifdef TMDS_TERC4_EN
      else if (m == 2'b10) w0 = terc4_tok(a);
`else
      else if (m == 2'b10) w0 = ctl_tok(c);
`endif
      w1 = w0;
      if (m == 2'b11) begin
        w0 = 10'h2CC;
        w1 = 10'h133;
      end
    end
  endtask

  // Drive one cycle of inputs and queue the response expected two edges after sampling.
  task automatic step(input logic r, input logic [1:0] m, input logic [7:0] p,
                      input logic [1:0] c, input logic [3:0] a);
    logic [9:0] w0;
    logic [9:0] w1;
    reset = r;
    mode = m;
    pix = p;
    ctl = c;
    aux = a;
    if (r) begin
      model_cnt = 0;
      // The character still in the output stage is discarded by reset.
      if (due_q.size() > 0 && due_q[due_q.size()-1] == edge_cnt + 1) begin
        exp0_q[exp0_q.size()-1] = 10'h354;
        exp1_q[exp1_q.size()-1] = 10'h354;
      end
      w0 = 10'h354;
      w1 = 10'h354;
    end else begin
      encode(m, p, c, a, w0, w1);
    end
    exp0_q.push_back(w0);
    exp1_q.push_back(w1);
    due_q.push_back(edge_cnt + 2);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    logic [9:0] e0;
    logic [9:0] e1;
    edge_cnt++;
    #1;
    if (due_q.size() > 0 && due_q[0] == edge_cnt) begin
      void'(due_q.pop_front());
      e0 = exp0_q.pop_front();
      e1 = exp1_q.pop_front();
      checks++;
      if (word0 !== e0) begin
        errors++;
        $display("FAIL ch0_word edge=%0d actual=%h required=%h", edge_cnt, word0, e0);
      end
      checks++;
      if (word1 !== e1) begin
        errors++;
        $display("FAIL ch1_word edge=%0d actual=%h required=%h", edge_cnt, word1, e1);
      end
    end
  end

  initial begin
    // Reset held with video request present
    step(1'b1, 2'b01, 8'hA5, 2'd0, 4'd0);
    step(1'b1, 2'b01, 8'hA5, 2'd0, 4'd0);
    step(1'b0, 2'b01, 8'hA5, 2'd0, 4'd0);
    // Control tokens
    for (int i = 0; i < 4; i++) step(1'b0, 2'b00, 8'($urandom), 2'(i), 4'($urandom));
    // Disparity walk, then control and 0xFF
    for (int i = 0; i < 4; i++) step(1'b0, 2'b01, 8'h00, 2'($urandom), 4'($urandom));
    step(1'b0, 2'b00, 8'h00, 2'd0, 4'd0);
    step(1'b0, 2'b01, 8'hFF, 2'd0, 4'd0);
    // Data island and guard band
    for (int i = 0; i < 16; i++) step(1'b0, 2'b10, 8'($urandom), 2'($urandom), 4'(i));
    step(1'b0, 2'b10, 8'h00, 2'd1, 4'hF);
    step(1'b0, 2'b11, 8'($urandom), 2'($urandom), 4'($urandom));
    step(1'b0, 2'b11, 8'($urandom), 2'($urandom), 4'($urandom));
    // Reset in the middle of a video run
    step(1'b0, 2'b01, 8'h00, 2'd0, 4'd0);
    step(1'b0, 2'b01, 8'h00, 2'd0, 4'd0);
    step(1'b1, 2'b01, 8'h00, 2'd0, 4'd0);
    step(1'b0, 2'b01, 8'h00, 2'd0, 4'd0);
    step(1'b0, 2'b01, 8'h3C, 2'd0, 4'd0);
    // Randomised traffic biased toward long video runs
    for (int i = 0; i < 600; i++) begin
      logic       r;
      logic [1:0] m;
      r = ($urandom_range(0, 49) == 0);
      m = ($urandom_range(0, 3) != 0) ? 2'b01 : 2'($urandom);
      step(r, m, 8'($urandom), 2'($urandom), 4'($urandom));
    end
    step(1'b0, 2'b00, 8'h00, 2'd0, 4'd0);
    repeat (4) @(negedge clk);
    checks++;
    if (due_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", due_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
